// File: rtl/nthash_md4_if.sv
// Handshake and data bundle between a hash requester and nthash_md4.
// The requester drives start/block. The core returns busy/hashrdy/hash.
interface nthash_md4_if;
  logic         start;
  logic [511:0] block;
  logic         busy;
  logic         hashrdy;
  logic [127:0] hash;

  modport master (
    output start,
    output block,
    input  busy,
    input  hashrdy,
    input  hash
  );

  modport slave (
    input  start,
    input  block,
    output busy,
    output hashrdy,
    output hash
  );
endinterface

// File: rtl/nthash_md4.sv
// Single-block MD4 core for NT hashes.
// It runs one step per cycle and has a fixed 50-cycle start-to-hashrdy latency.
module nthash_md4 (
  input  logic         clk,
  input  logic         reset,
  nthash_md4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [31:0] IA = 32'h67452301;
  localparam logic [31:0] IB = 32'hEFCDAB89;
  localparam logic [31:0] IC = 32'h98BADCFE;
  localparam logic [31:0] ID = 32'h10325476;

  state_t       r_state;
  logic [5:0]   r_step;
  logic [31:0]  r_a, r_b, r_c, r_d;
  logic [127:0] r_hash;
  logic         r_hashrdy;
  logic [31:0]  r_x [16];

  logic [31:0]  w_x [16];
  logic [31:0]  w_f;
  logic [31:0]  w_kc;
  logic [3:0]   w_k;
  logic [4:0]   w_s;
  logic [31:0]  w_sum;
  logic [31:0]  w_rot;
  logic [3:0]   w_i;
  logic [31:0]  w_fa, w_fb, w_fc, w_fd;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  assign w_i = r_step[3:0];

  assign w_fa = r_a + IA;
  assign w_fb = r_b + IB;
  assign w_fc = r_c + IC;
  assign w_fd = r_d + ID;

  // Split the incoming block into little-endian 32-bit message words.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_x[k] = {bus.block[511-8*(4*k+3) -: 8],
                bus.block[511-8*(4*k+2) -: 8],
                bus.block[511-8*(4*k+1) -: 8],
                bus.block[511-8*(4*k)   -: 8]};
    end
  end

  // Select round function, word index, constant and rotation for this step.
  always_comb begin
    w_f  = '0;
    w_kc = '0;
    w_k  = '0;
    w_s  = '0;
    unique case (1'b1)
      (r_step[5:4] == 2'd0): begin
        w_f  = (r_b & r_c) | (~r_b & r_d);
        w_kc = 32'h0;
        w_k  = w_i;
        unique case (w_i[1:0])
          2'd0: w_s = 5'd3;
          2'd1: w_s = 5'd7;
          2'd2: w_s = 5'd11;
          default: w_s = 5'd19;
        endcase
      end
      (r_step[5:4] == 2'd1): begin
        w_f  = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
        w_kc = 32'h5A827999;
        w_k  = {w_i[1:0], w_i[3:2]};
        unique case (w_i[1:0])
          2'd0: w_s = 5'd3;
          2'd1: w_s = 5'd5;
          2'd2: w_s = 5'd9;
          default: w_s = 5'd13;
        endcase
      end
      default: begin
        w_f  = r_b ^ r_c ^ r_d;
        w_kc = 32'h6ED9EBA1;
        w_k  = {w_i[0], w_i[1], w_i[2], w_i[3]};
        unique case (w_i[1:0])
          2'd0: w_s = 5'd3;
          2'd1: w_s = 5'd9;
          2'd2: w_s = 5'd11;
          default: w_s = 5'd15;
        endcase
      end
    endcase
  end

  assign w_sum = r_a + w_f + r_x[w_k] + w_kc;
  assign w_rot = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));

  // Capture the message words when a new hash is accepted.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.start) begin
      for (int k = 0; k < 16; k++) begin
        r_x[k] <= w_x[k];
      end
    end
  end

  // Main FSM: load, 48 compression steps, then finalize and publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_hash    <= '0;
      r_hashrdy <= 1'b0;
    end else begin
      r_hashrdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= IA;
            r_b     <= IB;
            r_c     <= IC;
            r_d     <= ID;
            r_step  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a    <= r_d;
          r_b    <= w_rot;
          r_c    <= r_b;
          r_d    <= r_c;
          r_step <= r_step + 6'd1;
          if (r_step == 6'd47) begin
            r_state <= FINAL;
          end
        end
        FINAL: begin
          r_a       <= w_fa;
          r_b       <= w_fb;
          r_c       <= w_fc;
          r_d       <= w_fd;
          r_hash    <= {bswap(w_fa), bswap(w_fb),
                        bswap(w_fc), bswap(w_fd)};
          r_hashrdy <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.hashrdy = r_hashrdy;
  assign bus.hash    = r_hash;

endmodule

// File: tb/tb_nthash_md4.sv
// Directed bench for nthash_md4: known NT-hash vectors plus
// busy-ignore, back-to-back, reset-abort and checker-match sequences.
module tb_nthash_md4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  nthash_md4_if bus ();

  nthash_md4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] H_EMPTY = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
  localparam logic [127:0] H_TEST  = 128'h0CB6948805F797BF2A82807973B89537;
  localparam logic [127:0] H_SWORD = 128'h61FB34469B9989B01BE4E8630C52EED6;
  localparam logic [127:0] H_1234  = 128'h7CE21F17C0AEE7FB9CEBA532D0546AD6;

  typedef struct {
    string        nm;
    logic [511:0] blk;
    logic [127:0] exp;
    logic         match;
  } vec_t;

  vec_t vecs [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] stored = H_TEST;
  logic         matchfound = 1'b0;

  // Stand-in for the downstream hash checker.
  always @(posedge clk) begin
    matchfound <= bus.hashrdy && (bus.hash == stored);
  end

  function automatic logic [511:0] mk(input string s);
    logic [511:0] b;
    logic [15:0]  bits;
    b = '0;
    for (int i = 0; i < s.len(); i++) begin
      b[511-16*i -: 8] = s[i];
    end
    b[511-16*s.len() -: 8] = 8'h80;
    bits = 16'(16 * s.len());
    b[511-8*56 -: 8] = bits[7:0];
    b[511-8*57 -: 8] = bits[15:8];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [511:0] blk);
    @(negedge clk);
    bus.block = blk;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (bus.hashrdy) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (bus.hashrdy) pulses++;
    end
  endtask

  int cyc;
  int pulses;
  logic [127:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.block = '0;

    vecs[0] = '{"empty",     mk(""),          H_EMPTY, 1'b0};
    vecs[1] = '{"test",      mk("test"),      H_TEST,  1'b1};
    vecs[2] = '{"swordfish", mk("swordfish"), H_SWORD, 1'b0};
    vecs[3] = '{"1234",      mk("1234"),      H_1234,  1'b0};

    #1;
    chk("reset_hash", bus.hash, '0);
    chk("reset_rdy", 128'(bus.hashrdy), 0);
    chk("reset_busy", 128'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 128'(bus.busy), 0);

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].blk);
      chk({vecs[v].nm, "_busy"}, 128'(bus.busy), 1);
      wait_rdy(cyc);
      chk({vecs[v].nm, "_latency"}, 128'(cyc), 49);
      chk({vecs[v].nm, "_hash"}, bus.hash, vecs[v].exp);
      @(posedge clk);
      #1;
      chk({vecs[v].nm, "_rdy_width"}, 128'(bus.hashrdy), 0);
      chk({vecs[v].nm, "_busy_done"}, 128'(bus.busy), 0);
      chk({vecs[v].nm, "_hold"}, bus.hash, vecs[v].exp);
      chk({vecs[v].nm, "_match"}, 128'(matchfound), 128'(vecs[v].match));
    end

    // start pulsed mid-run must be ignored
    launch(mk("test"));
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.block = mk("swordfish");
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    count_pulses(60, pulses);
    chk("ignore_pulses", 128'(pulses), 1);
    chk("ignore_hash", bus.hash, H_TEST);
    held = bus.hash;
    repeat (10) @(posedge clk);
    #1;
    chk("ignore_stable", bus.hash, H_TEST);
    chk("ignore_busy", 128'(bus.busy), 0);

    // start held high, block switched in the hashrdy cycle
    @(negedge clk);
    bus.block = mk("test");
    bus.start = 1'b1;
    wait_rdy(cyc);
    chk("b2b_first_lat", 128'(cyc), 50);
    chk("b2b_first_hash", bus.hash, H_TEST);
    bus.block = mk("swordfish");
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_rdy_width", 128'(bus.hashrdy), 0);
    chk("b2b_accepted", 128'(bus.busy), 1);
    wait_rdy(cyc);
    chk("b2b_gap", 128'(cyc + 1), 50);
    chk("b2b_second_hash", bus.hash, H_SWORD);

    // asynchronous reset mid-hash
    launch(mk("test"));
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_hash", bus.hash, '0);
    chk("rst_busy", 128'(bus.busy), 0);
    chk("rst_rdy", 128'(bus.hashrdy), 0);
    @(negedge clk);
    reset = 1'b0;
    count_pulses(60, pulses);
    chk("rst_no_pulse", 128'(pulses), 0);
    chk("rst_hash_kept", bus.hash, '0);
    launch(mk("test"));
    wait_rdy(cyc);
    chk("rst_after_lat", 128'(cyc), 49);
    chk("rst_after_hash", bus.hash, H_TEST);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
